// File: rtl/filter_pkg.sv
// Shared constants for the serial biquad filter: operand select codes,
// default datapath widths and the frame length used by the sequencer.
package filter_pkg;

    localparam int DW_DEF    = 16;
    localparam int CW_DEF    = 16;
    localparam int FRAC_DEF  = 14;
    localparam int GUARD_DEF = 3;

    // One multiply per cycle: 1 load/commit cycle + 5 products + 1 drain.
    localparam int FRAME_LEN = 7;

    typedef enum logic [2:0] {
        SEL_X0 = 3'd0,
        SEL_X1 = 3'd1,
        SEL_X2 = 3'd2,
        SEL_Y1 = 3'd3,
        SEL_Y2 = 3'd4
    } sel_e;

endpackage

// File: rtl/filter_datapath_if.sv
// Strobe/data bundle between the filter sequencer (master) and the
// arithmetic datapath (slave).
interface filter_datapath_if #(
    parameter int DW = 16,
    parameter int CW = 16
);
    logic signed [DW-1:0] x_in;
    logic signed [CW-1:0] b0;
    logic signed [CW-1:0] b1;
    logic signed [CW-1:0] b2;
    logic signed [CW-1:0] a1;
    logic signed [CW-1:0] a2;
    logic                 x_load;
    logic                 out_load;
    logic                 mult_en;
    logic                 mult_clr;
    logic                 acc_en;
    logic                 acc_clr;
    logic [2:0]           sel;
    logic signed [DW-1:0] y_out;
    logic                 y_valid;

    modport master (
        output x_in, b0, b1, b2, a1, a2,
        output x_load, out_load, mult_en, mult_clr, acc_en, acc_clr, sel,
        input  y_out, y_valid
    );

    modport slave (
        input  x_in, b0, b1, b2, a1, a2,
        input  x_load, out_load, mult_en, mult_clr, acc_en, acc_clr, sel,
        output y_out, y_valid
    );
endinterface

// File: rtl/filter_mac.sv
// Operand mux, signed multiply with optional negation (feedback taps),
// product register and guarded accumulator.
module filter_mac
    import filter_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF,
    parameter int GUARD = GUARD_DEF,
    localparam int PW   = DW + CW,
    localparam int AW   = DW + CW + GUARD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           sel,
    input  logic                 mult_en,
    input  logic                 mult_clr,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    input  logic signed [DW-1:0] x0,
    input  logic signed [DW-1:0] x1,
    input  logic signed [DW-1:0] x2,
    input  logic signed [DW-1:0] y1,
    input  logic signed [DW-1:0] y2,
    input  logic signed [CW-1:0] b0,
    input  logic signed [CW-1:0] b1,
    input  logic signed [CW-1:0] b2,
    input  logic signed [CW-1:0] a1,
    input  logic signed [CW-1:0] a2,
    output logic signed [AW-1:0] acc
);

    logic signed [DW-1:0] op;
    logic signed [CW-1:0] coef;
    logic                 neg;
    logic                 sel_ok;
    logic signed [PW-1:0] op_ext;
    logic signed [PW-1:0] coef_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] p_d, p_q;
    logic signed [AW-1:0] acc_d, acc_q;

    // Pick operand/coefficient pair; feedback taps are subtracted.
    always_comb begin
        op     = '0;
        coef   = '0;
        neg    = 1'b0;
        sel_ok = 1'b1;
        case (sel)
            SEL_X0:  begin op = x0; coef = b0; end
            SEL_X1:  begin op = x1; coef = b1; end
            SEL_X2:  begin op = x2; coef = b2; end
            SEL_Y1:  begin op = y1; coef = a1; neg = 1'b1; end
            SEL_Y2:  begin op = y2; coef = a2; neg = 1'b1; end
            default: sel_ok = 1'b0;
        endcase
        // Low PW bits of the product of sign-extended operands are exact.
        op_ext   = {{CW{op[DW-1]}}, op};
        coef_ext = {{DW{coef[CW-1]}}, coef};
        prod     = op_ext * coef_ext;
    end

    // Product register: clear wins, unused select codes load zero.
    always_comb begin
        p_d = p_q;
        if (mult_clr) begin
            p_d = '0;
        end else if (mult_en) begin
            if (!sel_ok)  p_d = '0;
            else if (neg) p_d = -prod;
            else          p_d = prod;
        end
    end

    // Accumulator: clear wins over accumulate.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr)     acc_d = '0;
        else if (acc_en) acc_d = acc_q + {{GUARD{p_q[PW-1]}}, p_q};
    end

    // Product and accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q   <= '0;
            acc_q <= '0;
        end else begin
            p_q   <= p_d;
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/filter_datapath.sv
// Biquad datapath: sample/output history, MAC, round-half-up and
// saturation ahead of the output register.
module filter_datapath
    import filter_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int GUARD = GUARD_DEF
) (
    input  logic          clk,
    input  logic          reset,
    filter_datapath_if.slave bus
);

    localparam int AW = DW + CW + GUARD;
    localparam logic signed [AW-1:0] HALF =
        {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [AW-1:0] Y_MAX =
        {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] Y_MIN =
        {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [DW-1:0] x0_d, x0_q, x1_d, x1_q, x2_d, x2_q;
    logic signed [DW-1:0] y1_d, y1_q, y2_d, y2_q;
    logic signed [DW-1:0] y_out_d, y_out_q;
    logic                 y_valid_d, y_valid_q;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_rnd;
    logic signed [AW-1:0] acc_shr;
    logic signed [DW-1:0] y_sat;

    filter_mac #(
        .DW    (DW),
        .CW    (CW),
        .GUARD (GUARD)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .sel      (bus.sel),
        .mult_en  (bus.mult_en),
        .mult_clr (bus.mult_clr),
        .acc_en   (bus.acc_en),
        .acc_clr  (bus.acc_clr),
        .x0       (x0_q),
        .x1       (x1_q),
        .x2       (x2_q),
        .y1       (y1_q),
        .y2       (y2_q),
        .b0       (bus.b0),
        .b1       (bus.b1),
        .b2       (bus.b2),
        .a1       (bus.a1),
        .a2       (bus.a2),
        .acc      (acc)
    );

    // Round half up, drop fraction bits, clamp to the sample range.
    always_comb begin
        acc_rnd = acc + HALF;
        acc_shr = acc_rnd >>> FRAC;
        if (acc_shr > Y_MAX)      y_sat = Y_MAX[DW-1:0];
        else if (acc_shr < Y_MIN) y_sat = Y_MIN[DW-1:0];
        else                      y_sat = acc_shr[DW-1:0];
    end

    // History shifts and output commit, each gated by its own strobe.
    always_comb begin
        x0_d      = x0_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        y1_d      = y1_q;
        y2_d      = y2_q;
        y_out_d   = y_out_q;
        y_valid_d = bus.out_load;
        if (bus.x_load) begin
            x0_d = bus.x_in;
            x1_d = x0_q;
            x2_d = x1_q;
        end
        if (bus.out_load) begin
            y_out_d = y_sat;
            y1_d    = y_sat;
            y2_d    = y1_q;
        end
    end

    // History and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x0_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
        end else begin
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            y1_q      <= y1_d;
            y2_q      <= y2_d;
            y_out_q   <= y_out_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign bus.y_out   = y_out_q;
    assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_filter_datapath.sv
// Scoreboard bench: the frame driver pushes the hand-computed value each
// commit must produce; a negedge monitor pops on every y_valid.
module tb_filter_datapath;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic signed [15:0] exp_q[$];

    always #5 clk = ~clk;

    filter_datapath_if #(.DW(16), .CW(16)) bus ();

    filter_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Monitor: every y_valid must match the oldest expected commit.
    always @(negedge clk) begin
        logic signed [15:0] e;
        if (bus.y_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid y_out=%0d (no commit pending)", bus.y_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.y_out !== e) begin
                    errors++;
                    $display("FAIL y_out got=%0d exp=%0d", bus.y_out, e);
                end
            end
        end
    end

    task automatic idle();
        bus.x_load   = 1'b0;
        bus.out_load = 1'b0;
        bus.mult_en  = 1'b0;
        bus.mult_clr = 1'b0;
        bus.acc_en   = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.sel      = 3'd0;
    endtask

    task automatic set_coef(input logic signed [15:0] c_b0, input logic signed [15:0] c_b1,
                            input logic signed [15:0] c_b2, input logic signed [15:0] c_a1,
                            input logic signed [15:0] c_a2);
        bus.b0 = c_b0;
        bus.b1 = c_b1;
        bus.b2 = c_b2;
        bus.a1 = c_a1;
        bus.a2 = c_a2;
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if (bus.y_out !== 16'sd0 || bus.y_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s y_out=%0d y_valid=%0b exp 0/0", name, bus.y_out, bus.y_valid);
        end
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_state("reset_state");
    endtask

    // mode: 0 normal, 1 sel=6 at t1, 2 mult_clr with mult_en at t1,
    // 3 acc_clr with acc_en at t6. stop_at truncates the frame.
    task automatic run_frame(input logic signed [15:0] x, input logic signed [15:0] exp_y,
                             input int mode = 0, input int stop_at = 7);
        for (int t = 0; t < 7; t++) begin
            if (t == stop_at) return;
            idle();
            if (t == 0) begin
                bus.x_in     = x;
                bus.x_load   = 1'b1;
                bus.out_load = 1'b1;
                bus.acc_clr  = 1'b1;
                exp_q.push_back(exp_y);
            end
            if (t >= 1 && t <= 5) begin
                bus.mult_en = 1'b1;
                bus.sel     = 3'(t - 1);
            end
            if (t >= 2) bus.acc_en = 1'b1;
            if (t == 6) bus.mult_clr = 1'b1;
            if (mode == 1 && t == 1) bus.sel = 3'd6;
            if (mode == 2 && t == 1) bus.mult_clr = 1'b1;
            if (mode == 3 && t == 6) bus.acc_clr = 1'b1;
            @(posedge clk); #1;
        end
        idle();
    endtask

    initial begin
        bus.x_in = '0;
        set_coef(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("initial_reset");

        // Passthrough
        do_reset();
        set_coef(16'sd16384, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        run_frame(16'sd1000, 16'sd0);
        run_frame(16'sd0,    16'sd1000);
        run_frame(16'sd0,    16'sd0);

        // FIR delay through b1 = 0.5
        do_reset();
        set_coef(16'sd0, 16'sd8192, 16'sd0, 16'sd0, 16'sd0);
        run_frame(16'sd1000, 16'sd0);
        run_frame(16'sd0,    16'sd0);
        run_frame(16'sd0,    16'sd500);
        run_frame(16'sd0,    16'sd0);

        // Feedback: y = x + 0.5*y1
        do_reset();
        set_coef(16'sd16384, 16'sd0, 16'sd0, -16'sd8192, 16'sd0);
        run_frame(16'sd1000, 16'sd0);
        run_frame(16'sd0,    16'sd1000);
        run_frame(16'sd0,    16'sd500);
        run_frame(16'sd0,    16'sd250);
        run_frame(16'sd0,    16'sd125);

        // Positive and negative saturation
        do_reset();
        set_coef(16'sd32767, 16'sd32767, 16'sd32767, 16'sd0, 16'sd0);
        run_frame(16'sd30000, 16'sd0);
        run_frame(16'sd30000, 16'sd32767);
        run_frame(16'sd30000, 16'sd32767);
        run_frame(16'sd30000, 16'sd32767);
        do_reset();
        run_frame(-16'sd30000, 16'sd0);
        run_frame(-16'sd30000, -16'sd32768);
        run_frame(-16'sd30000, -16'sd32768);

        // Rounding with b0 = 0.5
        do_reset();
        set_coef(16'sd8192, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        run_frame(16'sd3,  16'sd0);
        run_frame(-16'sd3, 16'sd2);
        run_frame(16'sd1,  -16'sd1);
        run_frame(16'sd0,  16'sd1);

        // Select/clear boundaries
        do_reset();
        set_coef(16'sd16384, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        run_frame(16'sd1000, 16'sd0);
        run_frame(16'sd1000, 16'sd1000, 1);
        run_frame(16'sd1000, 16'sd0,    2);
        run_frame(16'sd1000, 16'sd0,    3);
        run_frame(16'sd2000, 16'sd0);
        run_frame(16'sd0,    16'sd2000);

        // Reset at t3 discards the partial frame and all history
        do_reset();
        set_coef(16'sd16384, 16'sd16384, 16'sd0, 16'sd0, 16'sd0);
        run_frame(16'sd1000, 16'sd0);
        run_frame(16'sd500,  16'sd1000, 0, 3);
        do_reset();
        check_reset_state("midframe_reset");
        run_frame(16'sd0, 16'sd0);
        run_frame(16'sd0, 16'sd0);
        run_frame(16'sd0, 16'sd0);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_commits left=%0d exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_datapath.md
# filter_datapath

Arithmetic datapath for the serial biquad IIR filter. It is the responder to the filter sequencer: the sequencer issues per-cycle strobes and an operand select, and this block owns the sample history, multiplier register, accumulator, and output register. It computes y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2] with one multiply per cycle over a 7-cycle frame.

## Interface
- DW, 16, sample width (signed x_in, y_out)
- CW, 16, coefficient width (signed)
- FRAC, 14, coefficient fractional bits (Q2.14 by default)
- GUARD, 3, accumulator guard bits
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clears all state
- x_in  in  DW  new input sample, sampled on x_load
- b0, b1, b2, a1, a2  in  CW each  coefficients, held static by the integrator
- x_load  in  1  shift x history: x2<=x1, x1<=x0, x0<=x_in
- out_load  in  1  commit the accumulator to y_out and shift y history
- mult_en  in  1  capture the product selected by sel
- mult_clr  in  1  clear the product register
- acc_en  in  1  add the product register to the accumulator
- acc_clr  in  1  clear the accumulator
- sel  in  3  operand select: 0 x0·b0, 1 x1·b1, 2 x2·b2, 3 y1·a1 (negated), 4 y2·a2 (negated)
- y_out  out  DW  filtered sample, held between commits
- y_valid  out  1  one-cycle pulse in the cycle after out_load

## Operation
- Registers: x0, x1, x2, y1, y2 (DW), p (DW+CW), acc (DW+CW+GUARD), y_out, y_valid. All are 0 after reset.
- Product register p:
  - mult_clr takes priority: p<=0.
  - Otherwise, when mult_en is high, p <= operand·coef for sel 0–2, and p <= −(operand·coef) for sel 3–4.
  - For sel 5–7, p<=0.
- Accumulator: acc_clr takes priority (acc<=0). Otherwise, when acc_en is high, acc <= acc + sign-extended p.
- Commit on out_load: r = (acc + 2^(FRAC−1)) >>> FRAC (round half up), then saturate r to [−2^(DW−1), 2^(DW−1)−1]. Then y_out<=r, y1<=r, y2<=y1, and the next cycle y_valid<=1.
- Every register reads its old value when strobes coincide. acc_clr with out_load commits the pre-clear acc. x_load with mult_en(sel 0) multiplies the pre-shift x0.
- Frame schedule from the sequencer, 7 cycles t0..t6:
  - t0: x_load, out_load, acc_clr
  - t1..t5: mult_en with sel 0,1,2,3,4
  - t2..t6: acc_en
  - t6: mult_clr
- No internal FSM. The block acts only on strobes, so stalls (strobes held low) freeze all state.

## Timing
- The product registers one cycle after mult_en. The accumulator adds the value of p registered in the previous cycle.
- Latency: x_in sampled at t0 of frame k appears on y_out after t0 of frame k+1, 7 cycles later. y_valid goes high in t1 of frame k+1.
- The first frame after reset commits y_out=0 with y_valid=1.
- Reset mid-frame: all history, p, acc, and outputs go to 0 on the next edge. The partial frame is discarded.
- Saturation and rounding are combinational ahead of the y_out/y1 registers; they add no extra cycle.

## Structure
- filter_pkg holds:
  - the SEL_X0..SEL_Y2 codes
  - default DW/CW/FRAC/GUARD
  - the 7-cycle frame length constant, shared with the sequencer
- Sub-module filter_mac: the sel mux, multiplier/negation, p register, and accumulator with clear priority.
- The top level keeps the history registers, round/saturate logic, y_out, and y_valid.

## Test plan
- Passthrough: b0=16384, others 0; x_in=1000 at t0 → y_out=1000 at the next t0 commit; y_valid pulses once per frame.
- FIR delay: b1=8192, others 0; x sequence 1000,0,0 → y 0,500,0 in frames k+1..k+3.
- Feedback: b0=16384, a1=−8192; impulse 1000 → y 1000,500,250,125.
- Saturation: b0=b1=b2=32767; constant x=30000 → y_out=32767. With x=−30000 → y_out=−32768.
- Rounding: b0=8192. x=3 → 2; x=−3 → −1; x=1 → 1 (0.5 rounds up).
- Boundaries: mult_en with sel=6 → p=0. mult_clr with mult_en → p=0. acc_clr with acc_en → acc=0. Reset asserted at t3 → y_out=0, y_valid=0, and the next frame starts from a clean history.
